// File: rtl/mem_stage_ls.sv
// mem_stage_ls: memory pipeline stage between EX and WB.
// Performs RV32/RV64 loads and stores over a ready-handshaked data-memory port
// with variable latency. It generates byte enables, aligns store data, and
// sign/zero-extends load data. It flags misaligned or illegal accesses
// (fault_o) and waits that run past TIMEOUT (bus_err_o). It stalls upstream
// while memory is busy and registers the writeback triple.
//
// Ports:
//   clk, rst            clock (rising edge), async active-low reset
//   valid_i .. wd_i     EX->MEM instruction fields (held by upstream while stall_o=1)
//   stall_o             upstream must hold its inputs this cycle
//   dmem_*              data-memory request / response port
//   wb_d_o/wb_a_o/wb_we_o  registered writeback data / register / enable
//   bp_mem_o            combinational copy of alu_out_i for forwarding
//   fault_o, bus_err_o  registered one-cycle error pulses
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | accept a new instruction; zero-wait accesses complete here
// ST_WAIT | memory busy; latched request held on the port until ready/timeout
module mem_stage_ls #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [XLEN-1:0]       alu_out_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic                  reg_we_i,
    input  logic                  mem_re_i,
    input  logic                  mem_we_i,
    input  logic [2:0]            funct3_i,
    input  logic [XLEN-1:0]       wd_i,
    output logic                  stall_o,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [XLEN-1:0]       dmem_addr_o,
    output logic [XLEN-1:0]       dmem_wdata_o,
    output logic [XLEN/8-1:0]     dmem_be_o,
    input  logic                  dmem_ready_i,
    input  logic [XLEN-1:0]       dmem_rdata_i,
    output logic [XLEN-1:0]       wb_d_o,
    output logic [REG_ADDR_W-1:0] wb_a_o,
    output logic                  wb_we_o,
    output logic [XLEN-1:0]       bp_mem_o,
    output logic                  fault_o,
    output logic                  bus_err_o
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    typedef enum logic [0:0] {ST_IDLE, ST_WAIT} state_t;

    state_t                  state;
    logic [7:0]              cnt;

    logic [XLEN-1:0]         addr_q;
    logic [XLEN-1:0]         wdata_q;
    logic [NB-1:0]           be_q;
    logic                    we_q;
    logic [REG_ADDR_W-1:0]   rd_q;
    logic [2:0]              f3_q;
    logic [OFFW-1:0]         off_q;
    logic                    reg_we_q;

    logic                    access;
    logic                    illegal;
    logic                    misaligned;
    logic                    legal;
    logic [1:0]              size;
    logic [OFFW-1:0]         off;
    logic [NB-1:0]           mask;
    logic [NB-1:0]           be_c;
    logic [XLEN-1:0]         wdata_c;
    logic [XLEN-1:0]         addr_c;

    logic [2:0]              cur_f3;
    logic [OFFW-1:0]         cur_off;
    logic [XLEN-1:0]         shifted;
    logic [XLEN-1:0]         load_data;
    logic                    ext_bit;
    int                      nbits;

    // Decode of the incoming instruction (only meaningful in ST_IDLE).
    always_comb begin
        size   = funct3_i[1:0];
        off    = alu_out_i[OFFW-1:0];
        access = valid_i & (mem_re_i | mem_we_i);

        // 111 is never legal; unsigned stores do not exist; RV32 has no D or LWU.
        illegal = (funct3_i == 3'b111) | (mem_we_i & funct3_i[2])
                | ((XLEN == 32) & ((size == 2'b11) | (funct3_i == 3'b110)));

        case (size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = |off[1:0];
            default: misaligned = |off;
        endcase

        legal = access & ~illegal & ~misaligned;

        case (size)
            2'b00:   mask = NB'(1);
            2'b01:   mask = NB'(3);
            2'b10:   mask = NB'(15);
            default: mask = {NB{1'b1}};
        endcase
        be_c = mask << off;

        // Replicating the low bytes across every lane of the access size puts
        // the data under the enabled lanes without a variable shifter.
        case (size)
            2'b00:   wdata_c = {NB{wd_i[7:0]}};
            2'b01:   wdata_c = {(NB/2){wd_i[15:0]}};
            2'b10:   wdata_c = {(XLEN/32){wd_i[31:0]}};
            default: wdata_c = wd_i;
        endcase

        addr_c = {alu_out_i[XLEN-1:OFFW], {OFFW{1'b0}}};
    end

    // Load alignment and extension; uses the latched copy while waiting.
    always_comb begin
        cur_f3  = (state == ST_WAIT) ? f3_q  : funct3_i;
        cur_off = (state == ST_WAIT) ? off_q : off;
        shifted = dmem_rdata_i >> {cur_off, 3'b000};

        case (cur_f3[1:0])
            2'b00:   begin nbits = 8;    ext_bit = shifted[7];  end
            2'b01:   begin nbits = 16;   ext_bit = shifted[15]; end
            2'b10:   begin nbits = 32;   ext_bit = shifted[31]; end
            default: begin nbits = XLEN; ext_bit = 1'b0;        end
        endcase
        ext_bit = ext_bit & ~cur_f3[2];

        load_data = '0;
        for (int i = 0; i < XLEN; i++) begin
            load_data[i] = (i < nbits) ? shifted[i] : ext_bit;
        end
    end

    // Request and stall are combinational so zero-wait accesses cost no cycle;
    // gating with rst forces them low as soon as reset asserts.
    always_comb begin
        if (state == ST_WAIT) begin
            dmem_req_o   = rst;
            stall_o      = rst & ~dmem_ready_i;
            dmem_addr_o  = addr_q;
            dmem_wdata_o = wdata_q;
            dmem_be_o    = be_q;
            dmem_we_o    = rst & we_q;
        end else begin
            dmem_req_o   = rst & legal;
            stall_o      = rst & legal & ~dmem_ready_i;
            dmem_addr_o  = addr_c;
            dmem_wdata_o = wdata_c;
            dmem_be_o    = be_c;
            dmem_we_o    = rst & legal & mem_we_i;
        end
    end

    assign bp_mem_o = alu_out_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            wb_d_o    <= '0;
            wb_a_o    <= '0;
            wb_we_o   <= 1'b0;
            fault_o   <= 1'b0;
            bus_err_o <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            we_q      <= 1'b0;
            rd_q      <= '0;
            f3_q      <= '0;
            off_q     <= '0;
            reg_we_q  <= 1'b0;
        end else begin
            wb_we_o   <= 1'b0;
            fault_o   <= 1'b0;
            bus_err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (valid_i & ~access) begin
                        wb_d_o  <= alu_out_i;
                        wb_a_o  <= rd_i;
                        wb_we_o <= reg_we_i;
                    end else if (access & ~legal) begin
                        fault_o <= 1'b1;
                    end else if (legal & dmem_ready_i) begin
                        if (!mem_we_i) begin
                            wb_d_o  <= load_data;
                            wb_a_o  <= rd_i;
                            wb_we_o <= reg_we_i;
                        end
                    end else if (legal) begin
                        addr_q   <= addr_c;
                        wdata_q  <= wdata_c;
                        be_q     <= be_c;
                        we_q     <= mem_we_i;
                        rd_q     <= rd_i;
                        f3_q     <= funct3_i;
                        off_q    <= off;
                        reg_we_q <= reg_we_i;
                        cnt      <= '0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Ready on the final counted cycle still completes normally.
                    if (dmem_ready_i) begin
                        if (!we_q) begin
                            wb_d_o  <= load_data;
                            wb_a_o  <= rd_q;
                            wb_we_o <= reg_we_q;
                        end
                        state <= ST_IDLE;
                    end else if (cnt == 8'(TIMEOUT - 1)) begin
                        // cnt counts completed wait cycles, so this is the
                        // TIMEOUT-th cycle spent in ST_WAIT.
                        bus_err_o <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ls.sv
module tb_mem_stage_ls;

    typedef struct {
        logic [1:0]  kind;   // 0 = writeback, 1 = fault, 2 = bus error
        logic [4:0]  rd;
        logic [63:0] data;
        int          cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    ev_t  q_a[$];
    ev_t  q_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // XLEN=32 instance
    logic        a_valid, a_re, a_we, a_rwe, a_ready;
    logic [31:0] a_alu, a_wd, a_rdata;
    logic [4:0]  a_rd;
    logic [2:0]  a_f3;
    logic        a_stall, a_req, a_dwe, a_wb_we, a_fault, a_bus_err;
    logic [31:0] a_addr, a_wdata, a_wb_d, a_bp;
    logic [3:0]  a_be;
    logic [4:0]  a_wb_a;

    mem_stage_ls #(.XLEN(32), .REG_ADDR_W(5), .TIMEOUT(4)) dut32 (
        .clk(clk), .rst(rst), .valid_i(a_valid), .alu_out_i(a_alu), .rd_i(a_rd),
        .reg_we_i(a_rwe), .mem_re_i(a_re), .mem_we_i(a_we), .funct3_i(a_f3), .wd_i(a_wd),
        .stall_o(a_stall), .dmem_req_o(a_req), .dmem_we_o(a_dwe), .dmem_addr_o(a_addr),
        .dmem_wdata_o(a_wdata), .dmem_be_o(a_be), .dmem_ready_i(a_ready), .dmem_rdata_i(a_rdata),
        .wb_d_o(a_wb_d), .wb_a_o(a_wb_a), .wb_we_o(a_wb_we), .bp_mem_o(a_bp),
        .fault_o(a_fault), .bus_err_o(a_bus_err)
    );

    // XLEN=64 instance
    logic        b_valid, b_re, b_we, b_rwe, b_ready;
    logic [63:0] b_alu, b_wd, b_rdata;
    logic [4:0]  b_rd;
    logic [2:0]  b_f3;
    logic        b_stall, b_req, b_dwe, b_wb_we, b_fault, b_bus_err;
    logic [63:0] b_addr, b_wdata, b_wb_d, b_bp;
    logic [7:0]  b_be;
    logic [4:0]  b_wb_a;

    mem_stage_ls #(.XLEN(64), .REG_ADDR_W(5), .TIMEOUT(4)) dut64 (
        .clk(clk), .rst(rst), .valid_i(b_valid), .alu_out_i(b_alu), .rd_i(b_rd),
        .reg_we_i(b_rwe), .mem_re_i(b_re), .mem_we_i(b_we), .funct3_i(b_f3), .wd_i(b_wd),
        .stall_o(b_stall), .dmem_req_o(b_req), .dmem_we_o(b_dwe), .dmem_addr_o(b_addr),
        .dmem_wdata_o(b_wdata), .dmem_be_o(b_be), .dmem_ready_i(b_ready), .dmem_rdata_i(b_rdata),
        .wb_d_o(b_wb_d), .wb_a_o(b_wb_a), .wb_we_o(b_wb_we), .bp_mem_o(b_bp),
        .fault_o(b_fault), .bus_err_o(b_bus_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_a(input logic v, input logic re, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                         input logic rwe);
        a_valid = v; a_re = re; a_we = we; a_f3 = f3; a_alu = addr; a_wd = wd; a_rd = rd; a_rwe = rwe;
    endtask

    task automatic drv_b(input logic v, input logic re, input logic we, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wd, input logic [4:0] rd,
                         input logic rwe);
        b_valid = v; b_re = re; b_we = we; b_f3 = f3; b_alu = addr; b_wd = wd; b_rd = rd; b_rwe = rwe;
    endtask

    task automatic idle_a();
        drv_a(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        a_ready = 1'b0; a_rdata = 32'h0;
    endtask

    task automatic idle_b();
        drv_b(1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 5'd0, 1'b0);
        b_ready = 1'b0; b_rdata = 64'h0;
    endtask

    task automatic exp_a(input logic [1:0] k, input logic [4:0] rd, input logic [63:0] d, input int dc);
        ev_t e;
        e.kind = k; e.rd = rd; e.data = d; e.cyc = cyc + dc;
        q_a.push_back(e);
    endtask

    task automatic exp_b(input logic [1:0] k, input logic [4:0] rd, input logic [63:0] d, input int dc);
        ev_t e;
        e.kind = k; e.rd = rd; e.data = d; e.cyc = cyc + dc;
        q_b.push_back(e);
    endtask

    // Monitors: every writeback / fault / bus error pulse must match the next expected event.
    always @(negedge clk) begin
        ev_t e;
        logic [1:0] k;
        if (a_wb_we | a_fault | a_bus_err) begin
            k = a_wb_we ? 2'd0 : (a_fault ? 2'd1 : 2'd2);
            n_tests++;
            if (q_a.size() == 0) begin
                n_fail++;
                $display("FAIL d32_event: got kind %0d at cycle %0d, required no event", k, cyc);
            end else begin
                e = q_a.pop_front();
                if (k != e.kind || cyc != e.cyc ||
                    (k == 2'd0 && (64'(a_wb_d) != e.data || a_wb_a != e.rd))) begin
                    n_fail++;
                    $display("FAIL d32_event: got kind %0d cyc %0d rd %0d data 0x%0h, required kind %0d cyc %0d rd %0d data 0x%0h",
                             k, cyc, a_wb_a, a_wb_d, e.kind, e.cyc, e.rd, e.data);
                end
            end
        end
    end

    always @(negedge clk) begin
        ev_t e;
        logic [1:0] k;
        if (b_wb_we | b_fault | b_bus_err) begin
            k = b_wb_we ? 2'd0 : (b_fault ? 2'd1 : 2'd2);
            n_tests++;
            if (q_b.size() == 0) begin
                n_fail++;
                $display("FAIL d64_event: got kind %0d at cycle %0d, required no event", k, cyc);
            end else begin
                e = q_b.pop_front();
                if (k != e.kind || cyc != e.cyc ||
                    (k == 2'd0 && (b_wb_d != e.data || b_wb_a != e.rd))) begin
                    n_fail++;
                    $display("FAIL d64_event: got kind %0d cyc %0d rd %0d data 0x%0h, required kind %0d cyc %0d rd %0d data 0x%0h",
                             k, cyc, b_wb_a, b_wb_d, e.kind, e.cyc, e.rd, e.data);
                end
            end
        end
    end

    initial begin
        idle_a();
        idle_b();
        // Reset with a legal load already presented: request/stall must stay low.
        #1 rst = 1'b0;
        drv_a(1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd3, 1'b1);
        #1;
        chk("rst_req", 64'(a_req), 64'd0);
        chk("rst_stall", 64'(a_stall), 64'd0);
        chk("rst_wb_we", 64'(a_wb_we), 64'd0);
        chk("rst_wb_d", 64'(a_wb_d), 64'd0);
        chk("rst_wb_a", 64'(a_wb_a), 64'd0);
        chk("rst_fault", 64'(a_fault), 64'd0);
        chk("rst_bus_err", 64'(a_bus_err), 64'd0);
        chk("rst_req64", 64'(b_req), 64'd0);
        idle_a();
        #10 rst = 1'b1;
        step();

        // Zero-wait LB / LBU at 0x1003
        drv_a(1'b1, 1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 5'd5, 1'b1);
        a_ready = 1'b1; a_rdata = 32'h80123456;
        exp_a(2'd0, 5'd5, 64'hFFFFFF80, 1);
        #2;
        chk("lb_req", 64'(a_req), 64'd1);
        chk("lb_stall", 64'(a_stall), 64'd0);
        chk("lb_addr", 64'(a_addr), 64'h1000);
        chk("lb_be", 64'(a_be), 64'h8);
        step();
        drv_a(1'b1, 1'b1, 1'b0, 3'b100, 32'h1003, 32'h0, 5'd6, 1'b1);
        exp_a(2'd0, 5'd6, 64'h00000080, 1);
        step();

        // SH at 0x2002
        drv_a(1'b1, 1'b0, 1'b1, 3'b001, 32'h2002, 32'h1234ABCD, 5'd7, 1'b1);
        #2;
        chk("sh_be", 64'(a_be), 64'hC);
        chk("sh_wdata", 64'(a_wdata), 64'hABCDABCD);
        chk("sh_addr", 64'(a_addr), 64'h2000);
        chk("sh_dwe", 64'(a_dwe), 64'd1);
        step();

        // Misaligned LW, LD on RV32, unsigned store: fault, no request, no stall
        drv_a(1'b1, 1'b1, 1'b0, 3'b010, 32'h3001, 32'h0, 5'd8, 1'b1);
        exp_a(2'd1, 5'd0, 64'h0, 1);
        #2;
        chk("mis_req", 64'(a_req), 64'd0);
        chk("mis_stall", 64'(a_stall), 64'd0);
        step();
        drv_a(1'b1, 1'b1, 1'b0, 3'b011, 32'h3000, 32'h0, 5'd8, 1'b1);
        exp_a(2'd1, 5'd0, 64'h0, 1);
        #2;
        chk("ld32_req", 64'(a_req), 64'd0);
        step();
        drv_a(1'b1, 1'b0, 1'b1, 3'b100, 32'h3000, 32'h0, 5'd8, 1'b0);
        exp_a(2'd1, 5'd0, 64'h0, 1);
        step();

        // Non-memory ops: pass alu result through
        drv_a(1'b1, 1'b0, 1'b0, 3'b000, 32'h12345678, 32'h0, 5'd11, 1'b1);
        a_ready = 1'b0;
        exp_a(2'd0, 5'd11, 64'h12345678, 1);
        #2;
        chk("alu_stall", 64'(a_stall), 64'd0);
        chk("alu_bp", 64'(a_bp), 64'h12345678);
        step();
        drv_a(1'b1, 1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 5'd12, 1'b0);
        step();
        idle_a();
        step();

        // LW with three empty wait cycles; inputs change during the stall
        drv_a(1'b1, 1'b1, 1'b0, 3'b010, 32'h4000, 32'h0, 5'd7, 1'b1);
        exp_a(2'd0, 5'd7, 64'hDEADBEEF, 5);
        #2;
        chk("w_stall0", 64'(a_stall), 64'd1);
        step();
        for (int i = 1; i <= 3; i++) begin
            drv_a(1'b1, 1'b1, 1'b0, 3'b000, 32'h9991, 32'h0, 5'd9, 1'b0);
            #2;
            chk("w_stall", 64'(a_stall), 64'd1);
            chk("w_addr", 64'(a_addr), 64'h4000);
            chk("w_be", 64'(a_be), 64'hF);
            step();
        end
        a_ready = 1'b1; a_rdata = 32'hDEADBEEF;
        #2;
        chk("w_stall_rdy", 64'(a_stall), 64'd0);
        chk("w_req_rdy", 64'(a_req), 64'd1);
        step();
        idle_a();
        step();

        // Timeout: no ready at all
        drv_a(1'b1, 1'b1, 1'b0, 3'b010, 32'h5000, 32'h0, 5'd8, 1'b1);
        exp_a(2'd2, 5'd0, 64'h0, 5);
        step();
        idle_a();
        for (int i = 1; i <= 4; i++) begin
            #2;
            chk("to_req", 64'(a_req), 64'd1);
            chk("to_stall", 64'(a_stall), 64'd1);
            step();
        end
        #2;
        chk("to_req_off", 64'(a_req), 64'd0);
        chk("to_stall_off", 64'(a_stall), 64'd0);
        step();

        // Ready on the last counted cycle: completion wins
        drv_a(1'b1, 1'b1, 1'b0, 3'b001, 32'h6002, 32'h0, 5'd10, 1'b1);
        exp_a(2'd0, 5'd10, 64'hFFFF8001, 5);
        step();
        idle_a();
        for (int i = 1; i <= 3; i++) step();
        a_ready = 1'b1; a_rdata = 32'h80010000;
        #2;
        chk("edge_stall", 64'(a_stall), 64'd0);
        step();
        idle_a();
        step();
        step();

        // Reset while waiting: abandoned, no writeback or error
        drv_a(1'b1, 1'b1, 1'b0, 3'b010, 32'h7000, 32'h0, 5'd12, 1'b1);
        step();
        idle_a();
        step();
        #2 rst = 1'b0;
        #1;
        chk("mrst_req", 64'(a_req), 64'd0);
        chk("mrst_stall", 64'(a_stall), 64'd0);
        chk("mrst_wb_d", 64'(a_wb_d), 64'd0);
        chk("mrst_wb_we", 64'(a_wb_we), 64'd0);
        #2 rst = 1'b1;
        for (int i = 0; i < 6; i++) step();
        drv_a(1'b1, 1'b1, 1'b0, 3'b010, 32'h7004, 32'h0, 5'd12, 1'b1);
        a_ready = 1'b1; a_rdata = 32'hCAFEF00D;
        exp_a(2'd0, 5'd12, 64'hCAFEF00D, 1);
        #2;
        chk("post_req", 64'(a_req), 64'd1);
        step();
        idle_a();
        step();

        // XLEN=64
        drv_b(1'b1, 1'b1, 1'b0, 3'b011, 64'h8, 64'h0, 5'd1, 1'b1);
        b_ready = 1'b1; b_rdata = 64'h0123456789ABCDEF;
        exp_b(2'd0, 5'd1, 64'h0123456789ABCDEF, 1);
        #2;
        chk("ld_addr", b_addr, 64'h8);
        chk("ld_be", 64'(b_be), 64'hFF);
        step();
        drv_b(1'b1, 1'b1, 1'b0, 3'b110, 64'h4, 64'h0, 5'd2, 1'b1);
        b_rdata = 64'hFFFFFFFF00000000;
        exp_b(2'd0, 5'd2, 64'h00000000FFFFFFFF, 1);
        #2;
        chk("lwu_be", 64'(b_be), 64'hF0);
        step();
        drv_b(1'b1, 1'b1, 1'b0, 3'b010, 64'h4, 64'h0, 5'd3, 1'b1);
        exp_b(2'd0, 5'd3, 64'hFFFFFFFFFFFFFFFF, 1);
        step();
        drv_b(1'b1, 1'b0, 1'b1, 3'b010, 64'h14, 64'h1122334455667788, 5'd4, 1'b1);
        #2;
        chk("sw64_wdata", b_wdata, 64'h5566778855667788);
        chk("sw64_be", 64'(b_be), 64'hF0);
        chk("sw64_addr", b_addr, 64'h10);
        step();
        drv_b(1'b1, 1'b1, 1'b0, 3'b011, 64'hC, 64'h0, 5'd5, 1'b1);
        exp_b(2'd1, 5'd0, 64'h0, 1);
        #2;
        chk("ld_mis_req", 64'(b_req), 64'd0);
        step();
        drv_b(1'b1, 1'b1, 1'b0, 3'b001, 64'h6, 64'h0, 5'd6, 1'b1);
        b_rdata = 64'h8765000000000000;
        exp_b(2'd0, 5'd6, 64'hFFFFFFFFFFFF8765, 1);
        #2;
        chk("lh64_be", 64'(b_be), 64'hC0);
        step();
        idle_b();
        for (int i = 0; i < 3; i++) step();

        chk("q32_drained", 64'(q_a.size()), 64'd0);
        chk("q64_drained", 64'(q_b.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_ls.md
# mem_stage_ls

Parametrised memory pipeline stage between EX and WB of the RISC-V core. Performs RV32/RV64 loads and stores of byte, halfword, word (and doubleword when XLEN=64) over a ready-handshaked data-memory port with variable latency. Generates byte enables, aligns store data, and sign/zero-extends load data. Detects misaligned and timed-out accesses, stalls upstream while memory is busy, and registers the writeback triple (data, address, enable).

## Interface
Parameters:
- XLEN, 32, datapath and address width; legal values 32 or 64.
- REG_ADDR_W, 5, register-number width.
- TIMEOUT, 15, max wait cycles in WAIT before abort; legal 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- valid_i  in  1  EX→MEM instruction valid.
- alu_out_i  in  XLEN  effective address, or ALU result for non-memory ops.
- rd_i  in  REG_ADDR_W  destination register.
- reg_we_i  in  1  instruction writes rd.
- mem_re_i / mem_we_i  in  1 each  load / store request; never both 1.
- funct3_i  in  3  access size/sign, RISC-V encoding.
- wd_i  in  XLEN  store data, right-aligned.
- stall_o  out  1  upstream must hold all *_i inputs this cycle.
- dmem_req_o, dmem_we_o  out  1 each  request valid / write.
- dmem_addr_o  out  XLEN  address with low log2(XLEN/8) bits cleared.
- dmem_wdata_o  out  XLEN  lane-aligned store data.
- dmem_be_o  out  XLEN/8  byte enables.
- dmem_ready_i  in  1  memory accepts/completes request this cycle.
- dmem_rdata_i  in  XLEN  full-width read data, valid when dmem_ready_i=1.
- wb_d_o, wb_a_o, wb_we_o  out  XLEN / REG_ADDR_W / 1  registered writeback.
- bp_mem_o  out  XLEN  combinational alu_out_i, for forwarding.
- fault_o  out  1  registered one-cycle pulse: misaligned or illegal size.
- bus_err_o  out  1  registered one-cycle pulse: timeout abort.

## Operation
- Access = valid_i & (mem_re_i | mem_we_i). Offset off = alu_out_i[log2(XLEN/8)-1:0].
- Sizes: funct3[1:0] 00=B, 01=H, 10=W, 11=D. funct3[2]=1 means zero-extend (loads only). Illegal: D or LWU (110) when XLEN=32; any funct3[2]=1 store; 111 in any width.
- Misaligned: H with off[0]≠0; W with off[1:0]≠0; D with off≠0. Misaligned or illegal → no dmem request, fault_o pulses, wb_we_o=0, no stall.
- Byte enables: size-wide mask shifted left by off. wdata: wd_i low bytes replicated across all lanes of that size.
- Load result: dmem_rdata_i >> (8*off), truncated to size, then sign- or zero-extended to XLEN.
- Non-access valid instruction: wb_d=alu_out_i, wb_we=reg_we_i, one cycle, no stall.
- FSM states:
  - IDLE: on legal access, drive dmem_req_o combinationally from inputs. If dmem_ready_i=1, complete now. Otherwise set stall_o=1, latch the request (addr, be, wdata, we, rd, funct3, reg_we), clear the counter, and go to WAIT.
  - WAIT: dmem_req_o=1 with latched fields and stall_o=1. Counter increments each cycle. On dmem_ready_i=1, complete with latched fields and go to IDLE. If the counter reaches TIMEOUT with no ready, drop the request, pulse bus_err_o, write nothing, and go to IDLE.
- Completion: load → wb_we_o=reg_we, wb_d_o=extended data. Store → wb_we_o=0.
- Any cycle without completion or non-access retire registers wb_we_o=0 (bubble). wb_d_o and wb_a_o may hold stale values.
- rd=0 is passed through unchanged; the regfile ignores it.

## Timing
- Reset: state=IDLE, counter=0. wb_d_o=0, wb_a_o=0, wb_we_o=0, fault_o=0, bus_err_o=0. dmem_req_o and stall_o=0 immediately (asynchronous).
- Zero-wait access (ready in request cycle N): writeback registered at N+1, no stall.
- k wait cycles (ready at N+k): stall_o high for cycles N..N+k-1, writeback at N+k+1.
- Timeout: request in cycle N with no ready → dmem_req_o high for N..N+TIMEOUT, bus_err_o at N+TIMEOUT+1, stall_o released at N+TIMEOUT+1.
- Ready arriving in the same cycle the counter reaches TIMEOUT → completion wins, no bus_err_o.
- Reset asserted in WAIT: request is abandoned, no writeback, no error pulse.
- Inputs while stall_o=1 are ignored in WAIT; the latched copy is used.
- New access is accepted in the cycle after completion, giving back-to-back zero-wait throughput of 1 per cycle.

## Test plan
- Zero-wait LB, XLEN=32: addr 0x1003, rdata 0x80xxxxxx → wb_d_o=0xFFFFFF80 at N+1. Repeat as LBU → 0x00000080.
- SH, wd=0x1234ABCD, addr 0x2002 → dmem_be_o=4'b1100, dmem_wdata_o=0xABCDABCD, dmem_addr_o=0x2000, wb_we_o=0.
- LW at addr 0x3001 → fault_o pulse, dmem_req_o never 1, wb_we_o=0, stall_o=0.
- LW with ready after 3 waits → stall_o high for 4 cycles, wb_we_o=1 for exactly one cycle, rd matches the latched value even though inputs change during the stall.
- No ready, TIMEOUT=4 → bus_err_o pulse at N+5, no writeback. Separately, ready in the counter=TIMEOUT cycle → normal completion.
- XLEN=64: LD at addr 0x8 → full 64-bit data. LWU with rdata upper word 0xFFFFFFFF, addr 0x4 → 0x00000000FFFFFFFF. Reset pulse mid-WAIT → all outputs 0, next access proceeds normally.
